// File: rtl/dm_store_buffer.sv
// dm_store_buffer: in-order FIFO write buffer between the MEM-stage store path
// and the word-addressed data memory, with youngest-match load forwarding.
// Optional store merging into the youngest entry is enabled by SB_MERGE_EN.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wd,
    input  logic [31:0] st_pc,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    input  logic        drain_stall,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    output logic        empty,
    output logic        full
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [31:0]      wd_q   [DEPTH];
    logic [31:0]      wd_d   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, youngest;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, merge;
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_ld_lsb;

    // Byte offset of the load address never participates in matching.
    assign unused_ld_lsb = ^ld_addr[1:0];
    assign youngest = tail_q - PTR_W'(1);

    // Status flags and the head entry presented to the data memory.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == DEPTH_C);
        dm_we   = !empty && !drain_stall;
        dm_addr = empty ? 32'h0 : addr_q[head_q];
        dm_wd   = empty ? 32'h0 : wd_q[head_q];
        dm_pc   = empty ? 32'h0 : pc_q[head_q];
    end

`ifdef SB_MERGE_EN
    // Merge into the youngest entry unless that entry is leaving this cycle.
    always_comb begin
        merge = st_valid && !empty &&
                (addr_q[youngest][31:2] == st_addr[31:2]) &&
                ((count_q > (PTR_W+1)'(1)) || !dm_we);
    end
`else
    // Every accepted store allocates a fresh entry.
    always_comb begin
        merge = 1'b0;
    end
`endif

    // Acceptance: a full buffer only takes a store it can merge.
    always_comb begin
        st_ready = !full || merge;
        push     = st_valid && st_ready && !merge;
    end

    // Next-state for entries, pointers and occupancy.
    always_comb begin
        addr_d  = addr_q;
        wd_d    = wd_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q] = st_addr;
            wd_d[tail_q]   = st_wd;
            pc_d[tail_q]   = st_pc;
            tail_d         = tail_q + PTR_W'(1);
        end
        if (merge) begin
            addr_d[youngest] = st_addr;
            wd_d[youngest]   = st_wd;
            pc_d[youngest]   = st_pc;
        end
        if (dm_we) head_d = head_q + PTR_W'(1);
        case ({push, dm_we})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Forwarding: walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = 32'h0;
        fwd_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) &&
                (addr_q[fwd_idx][31:2] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = wd_q[fwd_idx];
            end
        end
    end

    // State registers; entry storage needs no reset since count gates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        addr_q <= addr_d;
        wd_q   <= wd_d;
        pc_q   <= pc_d;
    end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_dm_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, st_valid, drain_stall;
    logic [31:0] st_addr, st_wd, st_pc, ld_addr;
    logic        st_ready, ld_hit, dm_we, empty, full;
    logic [31:0] ld_data, dm_addr, dm_wd, dm_pc;

    int tests = 0;
    int fails = 0;

    // Reference model: the buffer is just an ordered list of stores.
    logic [31:0] qa[$], qw[$], qp[$];
    logic        m_we, m_ready, m_merge;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_wd(st_wd), .st_pc(st_pc),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .drain_stall(drain_stall), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
        .empty(empty), .full(full)
    );

    function automatic logic [29:0] word(input logic [31:0] a);
        return a[31:2];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model at the falling edge.
    task automatic look();
        int n;
        logic        e_hit;
        logic [31:0] e_ld;
        @(negedge clk);
        n = qa.size();
        m_we = (n > 0) && !drain_stall;
        m_merge = 1'b0;
`ifdef SB_MERGE_EN
        if (st_valid && n > 0)
            m_merge = (word(qa[n-1]) == word(st_addr)) && (n > 1 || !m_we);
`endif
        m_ready = (n < DEPTH) || m_merge;
        e_hit = 1'b0;
        e_ld  = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            if (word(qa[i]) == word(ld_addr)) begin
                e_hit = 1'b1;
                e_ld  = qw[i];
                break;
            end
        end
        chk("empty",    empty,    32'(n == 0));
        chk("full",     full,     32'(n == DEPTH));
        chk("st_ready", st_ready, 32'(m_ready));
        chk("dm_we",    dm_we,    32'(m_we));
        chk("dm_addr",  dm_addr,  n > 0 ? qa[0] : 32'h0);
        chk("dm_wd",    dm_wd,    n > 0 ? qw[0] : 32'h0);
        chk("dm_pc",    dm_pc,    n > 0 ? qp[0] : 32'h0);
        chk("ld_hit",   ld_hit,   32'(e_hit));
        chk("ld_data",  ld_data,  e_ld);
    endtask

    // Advance one clock and apply the same decisions to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            qa.delete(); qw.delete(); qp.delete();
        end else begin
            if (m_we) begin
                void'(qa.pop_front()); void'(qw.pop_front()); void'(qp.pop_front());
            end
            if (m_merge) begin
                qa[qa.size()-1] = st_addr;
                qw[qw.size()-1] = st_wd;
                qp[qp.size()-1] = st_pc;
            end else if (st_valid && m_ready) begin
                qa.push_back(st_addr); qw.push_back(st_wd); qp.push_back(st_pc);
            end
        end
        #1;
    endtask

    task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        st_valid = v; st_addr = a; st_wd = d; st_pc = p;
    endtask

    initial begin
        // Reset held two cycles with a store pending.
        reset = 1'b1; drain_stall = 1'b0; ld_addr = 32'h40;
        set_st(1'b1, 32'h40, 32'h1234_5678, 32'h100);
        @(posedge clk); #1;
        look();
        chk("rst_empty",   empty,   32'h1);
        chk("rst_dm_we",   dm_we,   32'h0);
        chk("rst_ld_hit",  ld_hit,  32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        tick();

        // Single store then drain.
        reset = 1'b0; ld_addr = 32'h10;
        set_st(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h3000);
        look();
        chk("push_not_fwd", ld_hit, 32'h0);
        tick();
        st_valid = 1'b0;
        look();
        chk("single_we",   dm_we,   32'h1);
        chk("single_addr", dm_addr, 32'h10);
        chk("single_wd",   dm_wd,   32'hDEAD_BEEF);
        chk("single_pc",   dm_pc,   32'h3000);
        chk("single_fwd",  ld_data, 32'hDEAD_BEEF);
        tick();
        look();
        chk("single_empty", empty, 32'h1);
        tick();

        // Fill under stall, hold a fifth store, then release.
        drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h4000 + 32'(i * 4));
            look(); tick();
        end
        set_st(1'b1, 32'h30, 32'h5555_0005, 32'h4010);
        look();
        chk("fill_full",  full,     32'h1);
        chk("fill_ready", st_ready, 32'h0);
        tick();
        look(); tick();
        drain_stall = 1'b0;
        look();
        chk("drain0_addr",  dm_addr,  32'h0);
        chk("drain0_ready", st_ready, 32'h0);
        tick();
        look();
        chk("drain1_addr",  dm_addr,  32'h4);
        chk("fifth_accept", st_ready, 32'h1);
        tick();
        st_valid = 1'b0;
        look();
        chk("drain2_addr", dm_addr, 32'h8);
        tick();
        look();
        chk("drain3_addr", dm_addr, 32'hC);
        tick();
        look();
        chk("drain4_addr", dm_addr, 32'h30);
        tick();
        look(); tick();

        // Youngest-match forwarding.
        drain_stall = 1'b1;
        set_st(1'b1, 32'h20, 32'h1111_1111, 32'h5000); look(); tick();
        set_st(1'b1, 32'h24, 32'h2222_2222, 32'h5004); look(); tick();
        set_st(1'b1, 32'h22, 32'h3333_3333, 32'h5008); look(); tick();
        st_valid = 1'b0; ld_addr = 32'h20;
        look();
        chk("fwd_hit",  ld_hit,  32'h1);
        chk("fwd_data", ld_data, 32'h3333_3333);
        tick();
        ld_addr = 32'h28;
        look();
        chk("fwd_miss_hit",  ld_hit,  32'h0);
        chk("fwd_miss_data", ld_data, 32'h0);
        tick();
        drain_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin look(); tick(); end

        // Push every cycle while draining: occupancy stays at one, pointers wrap.
        for (int i = 0; i < 11; i++) begin
            set_st(1'b1, 32'h100 + 32'(i * 4), $urandom, 32'h6000 + 32'(i * 4));
            ld_addr = 32'h100 + 32'(i * 4) - 32'h4;
            look();
            if (i > 0) begin
                chk("pp_not_empty", empty, 32'h0);
                chk("pp_not_full",  full,  32'h0);
            end
            tick();
        end
        st_valid = 1'b0;
        look(); tick();
        look(); tick();

        // Full buffer, store to the youngest word.
        drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, 32'h50 + 32'(i * 4), 32'hB000_0000 + 32'(i), 32'h7000);
            look(); tick();
        end
        set_st(1'b1, 32'h5E, 32'hAAAA_5555, 32'h7010);
        look();
`ifdef SB_MERGE_EN
        chk("merge_ready", st_ready, 32'h1);
`else
        chk("merge_ready", st_ready, 32'h0);
`endif
        tick();
        st_valid = 1'b0;
        look();
        chk("merge_full", full, 32'h1);
        tick();
        drain_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin look(); tick(); end
        look(); tick();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            drain_stall = ($urandom_range(0, 2) == 0);
            set_st($urandom_range(0, 1) == 1,
                   32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3)),
                   $urandom, $urandom);
            ld_addr = 32'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
            look(); tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- FIFO write buffer between the MEM-stage store path and the word-addressed data memory.
- Accepts store requests (address, data, PC) from the pipeline and drains them into the data memory one per cycle, in order.
- Supplies youngest-match load forwarding so a load sees buffered stores that have not yet been committed.
- Lets stores retire without waiting on the memory port; drain is held off by a stall input.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; flushes the buffer.
- st_valid  in  1  store request this cycle.
- st_ready  out  1  buffer can accept the store this cycle.
- st_addr  in  32  store byte address; word index is st_addr[31:2].
- st_wd  in  32  store data.
- st_pc  in  32  PC of the store instruction, carried for trace.
- ld_addr  in  32  load byte address for forwarding lookup.
- ld_hit  out  1  a valid entry matches ld_addr[31:2].
- ld_data  out  32  data of the youngest matching entry; 0 when ld_hit=0.
- drain_stall  in  1  data memory cannot accept a write this cycle.
- dm_we  out  1  write enable to data memory.
- dm_addr  out  32  head entry address, full 32 bits as stored.
- dm_wd  out  32  head entry data.
- dm_pc  out  32  head entry PC.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- State: DEPTH entries of {addr, wd, pc}; head pointer, tail pointer, and count (PTR_W+1 bits).
- Reset (synchronous, active-high): head=tail=count=0.
  - At the next edge after reset: empty=1, full=0, dm_we=0, ld_hit=0, ld_data=0.
  - Entry contents are don't-care; dm_addr, dm_wd and dm_pc are 0 while empty.
- Push: st_fire = st_valid && st_ready.
  - st_ready = !full (plus the merge case, see Optional Feature).
  - No same-cycle pass-through when full, even if a pop occurs that cycle.
  - On posedge with st_fire: write the entry at tail, tail = tail+1 mod DEPTH.
- Pop/drain: dm_we = !empty && !drain_stall, combinational.
  - dm_addr, dm_wd and dm_pc show the head entry combinationally whenever the buffer is non-empty.
  - On posedge with dm_we: head = head+1 mod DEPTH.
  - Latency: an accepted store appears on dm_we no earlier than the cycle after acceptance (registered path, no bypass).
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
  - Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Forwarding: combinational.
  - Scan valid entries from youngest (tail-1) to oldest (head).
  - The first entry whose addr[31:2] == ld_addr[31:2] drives ld_hit=1 and ld_data.
  - The head entry still forwards in the cycle it drains.
  - A store being pushed in the same cycle is not visible to forwarding.
- Ordering: strict FIFO; the data memory observes writes in acceptance order.
- Boundaries:
  - st_valid while full (no merge): st_ready=0, store not taken, the source must hold it.
  - drain_stall held: head is held, dm_we=0, pushes continue until full.
  - Reset during any state: flush wins over a simultaneous push or pop; in-flight entries are discarded.
  - Unaligned st_addr is stored unmodified; matching and downstream indexing use bits [31:2] only.

Optional Feature:
- Macro: SB_MERGE_EN.
- Defined (store merging):
  - A merge occurs when st_valid=1, the buffer is non-empty, the youngest entry's addr[31:2] == st_addr[31:2], and the youngest entry is not being popped this cycle (i.e. count>1 or dm_we=0).
  - On a merge, the youngest entry's wd and pc are overwritten and its addr is replaced with st_addr.
  - A merge leaves tail and count unchanged.
  - st_ready=1 for a merge even when full.
- Undefined: every accepted store allocates a new entry; no merging logic is synthesized.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with st_valid=1 -> empty=1, dm_we=0, ld_hit=0, ld_data=0.
- Single store, no stall:
  - Push addr=0x0000_0010, wd=0xDEAD_BEEF, pc=0x0000_3000 -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF, dm_pc=0x3000.
  - The cycle after that: empty=1.
- Fill and hold: drain_stall=1, push 4 stores (0x0, 0x4, 0x8, 0xC) -> full=1 and st_ready=0.
  - A 5th store is held.
  - Release the stall -> writes drain in order 0x0, 0x4, 0x8, 0xC on consecutive cycles, and the 5th store is accepted the cycle after full drops.
- Forwarding youngest match: drain_stall=1, push 0x20/0x1111_1111 then 0x24/0x2222_2222 then 0x22/0x3333_3333 (word index 8).
  - ld_addr=0x20 -> ld_hit=1, ld_data=0x33333333.
  - ld_addr=0x28 -> ld_hit=0, ld_data=0.
- Simultaneous push/pop with wrap: keep count=1 while pushing every cycle for 10 cycles -> count stays 1, writes emerge in order, pointers wrap without loss.
- SB_MERGE_EN defined: drain_stall=1, buffer full, push to the tail's word address with wd=0xAAAA_5555 -> st_ready=1, count=4, and that entry later drains with 0xAAAA5555.
  - Without the macro, the same stimulus gives st_ready=0.
